// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle MIPS datapath.
// Sequences fetch -> decode -> execute -> memory -> writeback, drives the ALU
// operation code and all datapath enables, and consumes the ALU Zero flag.
// Optional feature macro: IMM_ALU_EN adds the immediate-ALU instructions
// (addi/andi/ori/slti) through the IEXEC/IWB states and the ExtOp output.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [3:0] ALUctl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
`ifdef IMM_ALU_EN
    output logic       ExtOp,
`endif
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_BAD = 4'd15;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] w_funct_ctl;
    logic       w_funct_valid;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
`ifdef IMM_ALU_EN
    logic [3:0] w_imm_ctl;
    logic       w_imm_zext;
`endif

    // State register; reset is sampled on the clock edge and always lands in FETCH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // R-type Funct to ALU code; unknown functions map to the invalid code.
    always_comb begin
        w_funct_ctl   = ALU_BAD;
        w_funct_valid = 1'b1;
        case (Funct)
            6'h20:   w_funct_ctl = ALU_ADD;
            6'h22:   w_funct_ctl = ALU_SUB;
            6'h24:   w_funct_ctl = ALU_AND;
            6'h25:   w_funct_ctl = ALU_OR;
            6'h27:   w_funct_ctl = ALU_NOR;
            6'h2A:   w_funct_ctl = ALU_SLT;
            default: w_funct_valid = 1'b0;
        endcase
    end

`ifdef IMM_ALU_EN
    // Immediate opcode to ALU code and immediate extension mode.
    always_comb begin
        w_imm_ctl  = ALU_ADD;
        w_imm_zext = 1'b0;
        case (Op)
            6'h0C: begin w_imm_ctl = ALU_AND; w_imm_zext = 1'b1; end
            6'h0D: begin w_imm_ctl = ALU_OR;  w_imm_zext = 1'b1; end
            6'h0A: w_imm_ctl = ALU_SLT;
            default: w_imm_ctl = ALU_ADD;
        endcase
    end
`endif

    // Next-state logic; unused state codes recover to FETCH.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    6'h23, 6'h2B: w_next_state = S_MEMADR;
                    6'h00:        w_next_state = S_EXEC;
                    6'h04:        w_next_state = S_BRANCH;
                    6'h02:        w_next_state = S_JUMP;
`ifdef IMM_ALU_EN
                    6'h08, 6'h0C, 6'h0D, 6'h0A: w_next_state = S_IEXEC;
`endif
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = (Op == 6'h23) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = S_MEMWB;
            S_EXEC:   w_next_state = S_RWB;
`ifdef IMM_ALU_EN
            S_IEXEC:  w_next_state = S_IWB;
`endif
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Moore output decode from the current state; write strobes are kept raw here.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned and no latch is inferred.
        ALUctl          = 4'd0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = 2'd0;
        PCSource        = 2'd0;
        IorD            = 1'b0;
        RegDst          = 1'b0;
        MemtoReg        = 1'b0;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
`ifdef IMM_ALU_EN
        ExtOp           = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                ALUSrcB    = 2'd1;
                ALUctl     = ALU_ADD;
            end
            S_DECODE: begin
                ALUSrcB = 2'd3;
                ALUctl  = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                ALUctl  = ALU_ADD;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                IorD       = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write = 1'b1;
                MemtoReg    = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                IorD        = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUctl  = w_funct_ctl;
            end
            S_RWB: begin
                w_reg_write = w_funct_valid;
                RegDst      = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA         = 1'b1;
                ALUctl          = ALU_SUB;
                w_pc_write_cond = 1'b1;
                PCSource        = 2'd1;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                PCSource   = 2'd2;
            end
`ifdef IMM_ALU_EN
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                ALUctl  = w_imm_ctl;
                ExtOp   = w_imm_zext;
            end
            S_IWB: begin
                w_reg_write = 1'b1;
            end
`endif
            default: begin
                ALUctl = 4'd0;
            end
        endcase
    end

    // Write and strobe outputs are held off for as long as reset is asserted.
    assign PCEn     = ~reset & (w_pc_write | (w_pc_write_cond & Zero));
    assign MemRead  = ~reset & w_mem_read;
    assign MemWrite = ~reset & w_mem_write;
    assign IRWrite  = ~reset & w_ir_write;
    assign RegWrite = ~reset & w_reg_write;
    assign State    = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-vector bench for multicycle_control.
// Expected per-cycle output bundles are written out by hand from the
// state table; IMM_ALU_EN selects the immediate-instruction scenario.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic [3:0] ALUctl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       PCEn;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic [3:0] State;
`ifdef IMM_ALU_EN
    logic       ExtOp;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .ALUctl   (ALUctl),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .PCSource (PCSource),
        .PCEn     (PCEn),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
`ifdef IMM_ALU_EN
        .ExtOp    (ExtOp),
`endif
        .State    (State)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
    } outs_t;

    localparam outs_t E_FETCH     = '{st:4'd0, alu:4'd2, srcb:2'd1, pcen:1'b1, mrd:1'b1, irw:1'b1, default:'0};
    localparam outs_t E_FETCH_RST = '{st:4'd0, alu:4'd2, srcb:2'd1, default:'0};
    localparam outs_t E_DECODE    = '{st:4'd1, alu:4'd2, srcb:2'd3, default:'0};
    localparam outs_t E_MEMADR    = '{st:4'd2, alu:4'd2, srca:1'b1, srcb:2'd2, default:'0};
    localparam outs_t E_MEMRD     = '{st:4'd3, iord:1'b1, mrd:1'b1, default:'0};
    localparam outs_t E_MEMWB     = '{st:4'd4, m2r:1'b1, rw:1'b1, default:'0};
    localparam outs_t E_MEMWR     = '{st:4'd5, iord:1'b1, mwr:1'b1, default:'0};
    localparam outs_t E_MEMWR_RST = '{st:4'd5, iord:1'b1, default:'0};
    localparam outs_t E_EXEC_SUB  = '{st:4'd6, alu:4'd6, srca:1'b1, default:'0};
    localparam outs_t E_RWB       = '{st:4'd7, rdst:1'b1, rw:1'b1, default:'0};
    localparam outs_t E_BR_TAKEN  = '{st:4'd8, alu:4'd6, srca:1'b1, pcsrc:2'd1, pcen:1'b1, default:'0};
    localparam outs_t E_BR_NOT    = '{st:4'd8, alu:4'd6, srca:1'b1, pcsrc:2'd1, default:'0};
    localparam outs_t E_JUMP      = '{st:4'd9, pcsrc:2'd2, pcen:1'b1, default:'0};
`ifdef IMM_ALU_EN
    localparam outs_t E_IEXEC_OR  = '{st:4'd10, alu:4'd1, srca:1'b1, srcb:2'd2, default:'0};
    localparam outs_t E_IWB       = '{st:4'd11, rw:1'b1, default:'0};
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run cannot hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic outs_t snap();
        outs_t o;
        o.st    = State;
        o.alu   = ALUctl;
        o.srca  = ALUSrcA;
        o.srcb  = ALUSrcB;
        o.pcsrc = PCSource;
        o.pcen  = PCEn;
        o.iord  = IorD;
        o.mrd   = MemRead;
        o.mwr   = MemWrite;
        o.irw   = IRWrite;
        o.rdst  = RegDst;
        o.m2r   = MemtoReg;
        o.rw    = RegWrite;
        return o;
    endfunction

    // Advance one clock and settle at the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        outs_t got;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        got = snap();
        n_tests++;
        if (got !== E_FETCH_RST) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected %h", got, E_FETCH_RST);
        end
        reset = 1'b0;
        #1;
        got = snap();
        n_tests++;
        if (got !== E_FETCH) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", got, E_FETCH);
        end
    endtask

    task automatic test_rtype_sub();
        outs_t exp_q[$] = '{E_FETCH, E_DECODE, E_EXEC_SUB, E_RWB, E_FETCH};
        outs_t got;
        Op = 6'h00; Funct = 6'h22; Zero = 1'b0;
        #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = snap();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rtype_sub cyc%0d: got %h expected %h", i, got, exp_q[i]);
            end
            if (i < exp_q.size() - 1) step();
        end
    endtask

    task automatic test_funct_map();
        logic [5:0] functs [6] = '{6'h20, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
        logic [3:0] alus   [6] = '{4'd2,  4'd0,  4'd1,  4'd12, 4'd7,  4'd15};
        outs_t got;
        outs_t e_exec;
        outs_t e_rwb;
        for (int k = 0; k < 6; k++) begin
            Op = 6'h00; Funct = functs[k];
            e_exec = '{st:4'd6, alu:alus[k], srca:1'b1, default:'0};
            e_rwb  = '{st:4'd7, rdst:1'b1, rw:(k != 5), default:'0};
            step();
            step();
            got = snap();
            n_tests++;
            if (got !== e_exec) begin
                n_fail++;
                $display("FAIL funct_%h exec: got %h expected %h", functs[k], got, e_exec);
            end
            step();
            got = snap();
            n_tests++;
            if (got !== e_rwb) begin
                n_fail++;
                $display("FAIL funct_%h rwb: got %h expected %h", functs[k], got, e_rwb);
            end
            step();
        end
    endtask

    task automatic test_lw();
        outs_t exp_q[$] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        outs_t got;
        Op = 6'h23; Funct = 6'h00;
        #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = snap();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL lw cyc%0d: got %h expected %h", i, got, exp_q[i]);
            end
            if (i < exp_q.size() - 1) step();
        end
    endtask

    task automatic test_beq(input logic zero_in);
        outs_t exp_q[$];
        outs_t got;
        exp_q = '{E_FETCH, E_DECODE, (zero_in ? E_BR_TAKEN : E_BR_NOT), E_FETCH};
        Op = 6'h04; Funct = 6'h00; Zero = zero_in;
        #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = snap();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL beq_z%0d cyc%0d: got %h expected %h", zero_in, i, got, exp_q[i]);
            end
            if (i < exp_q.size() - 1) step();
        end
        Zero = 1'b0;
    endtask

    task automatic test_jump();
        outs_t exp_q[$] = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        outs_t got;
        Op = 6'h02;
        #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = snap();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL jump cyc%0d: got %h expected %h", i, got, exp_q[i]);
            end
            if (i < exp_q.size() - 1) step();
        end
    endtask

    task automatic test_nop(input logic [5:0] op_in);
        outs_t exp_q[$] = '{E_FETCH, E_DECODE, E_FETCH};
        outs_t got;
        Op = op_in;
        #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = snap();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL nop_%h cyc%0d: got %h expected %h", op_in, i, got, exp_q[i]);
            end
            if (i < exp_q.size() - 1) step();
        end
    endtask

`ifdef IMM_ALU_EN
    task automatic test_imm_ori();
        outs_t exp_q[$] = '{E_FETCH, E_DECODE, E_IEXEC_OR, E_IWB, E_FETCH};
        logic  ext_q[$] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        outs_t got;
        Op = 6'h0D;
        #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = snap();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ori cyc%0d: got %h expected %h", i, got, exp_q[i]);
            end
            n_tests++;
            if (ExtOp !== ext_q[i]) begin
                n_fail++;
                $display("FAIL ori_extop cyc%0d: got %b expected %b", i, ExtOp, ext_q[i]);
            end
            if (i < exp_q.size() - 1) step();
        end
    endtask
`endif

    task automatic test_reset_mid_sw();
        outs_t exp_q[$] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
        outs_t got;
        Op = 6'h2B;
        #1;
        for (int i = 0; i < exp_q.size(); i++) begin
            got = snap();
            n_tests++;
            if (got !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sw cyc%0d: got %h expected %h", i, got, exp_q[i]);
            end
            if (i < exp_q.size() - 1) step();
        end
        reset = 1'b1;
        #1;
        got = snap();
        n_tests++;
        if (got !== E_MEMWR_RST) begin
            n_fail++;
            $display("FAIL sw_reset_memwr: got %h expected %h", got, E_MEMWR_RST);
        end
        step();
        got = snap();
        n_tests++;
        if (got !== E_FETCH_RST) begin
            n_fail++;
            $display("FAIL sw_reset_fetch: got %h expected %h", got, E_FETCH_RST);
        end
        reset = 1'b0;
        #1;
        got = snap();
        n_tests++;
        if (got !== E_FETCH) begin
            n_fail++;
            $display("FAIL sw_reset_release: got %h expected %h", got, E_FETCH);
        end
    endtask

    initial begin
        reset = 1'b1;
        Op    = 6'h00;
        Funct = 6'h00;
        Zero  = 1'b0;
        test_reset();
        test_rtype_sub();
        test_funct_map();
        test_lw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jump();
        test_nop(6'h3F);
`ifdef IMM_ALU_EN
        test_imm_ori();
`else
        test_nop(6'h0D);
`endif
        test_reset_mid_sw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
